fft_axis_framer: RTL and testbench

- Downstream consumer of the two-sample-per-clock bit-reversal stage; sits at the FFT output boundary.
- Accepts bit-reversed sample pairs qualified by i_ce plus the first-of-block sync, and packs each pair into one AXI-Stream beat.
- Buffers whole frames in a FIFO; marks start-of-frame (TUSER) and end-of-frame (TLAST).
- The FFT pipeline cannot be stalled, so a frame is admitted only if it fits completely; otherwise the whole frame is dropped and counted.

---
 rtl/fft_axis_framer.sv | 144 ++++++++++++++
 tb/tb_fft_axis_framer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_axis_framer.sv
// Packs bit-reversed FFT sample pairs into AXI-Stream beats, buffering whole frames.
// A frame is admitted only if it fits completely in the FIFO; otherwise it is dropped and counted.
module fft_axis_framer #(
   parameter int LGSIZE = 5,
   parameter int WIDTH  = 24,
   parameter int LGFIFO = 5
) (
   input  logic                 i_clk,
   input  logic                 i_areset_n,
   input  logic                 i_ce,
   input  logic [2*WIDTH-1:0]   i_sample_0,
   input  logic [2*WIDTH-1:0]   i_sample_1,
   input  logic                 i_sync,
   input  logic                 i_clear,
   output logic                 M_AXIS_TVALID,
   input  logic                 M_AXIS_TREADY,
   output logic [4*WIDTH-1:0]   M_AXIS_TDATA,
   output logic                 M_AXIS_TLAST,
   output logic                 M_AXIS_TUSER,
   output logic                 o_sync_err,
   output logic [15:0]          o_drop_count
);

   localparam int FRAME = 1 << (LGSIZE - 1);
   localparam int DEPTH = 1 << LGFIFO;
   localparam int IW    = LGSIZE - 1;
   localparam int FW    = 4 * WIDTH + 2;

   generate
      if (LGFIFO < LGSIZE - 1 || LGSIZE < 2) begin : gBadParams
         $error("fft_axis_framer: FIFO must hold at least one frame (LGFIFO >= LGSIZE-1, LGSIZE >= 2)");
      end
   endgenerate

   typedef enum logic [1:0] {S_WAIT, S_PASS, S_DROP} state_t;

   logic [1:0]        rstSync_q;
   logic              rstN;
   state_t            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [LGFIFO:0]   fill_q, fill_d;
   logic [LGFIFO-1:0] wrPtr_q, rdPtr_q;
   logic [FW-1:0]     mem [DEPTH];
   logic [FW-1:0]     wrWord, rdWord;
   logic              frameStart, admit, wrEn, pop, syncEvt, dropEvt;
   logic              tvalid_q, tlast_q, tuser_q;
   logic [4*WIDTH-1:0] tdata_q;
   logic              syncErr_q, syncErr_d;
   logic [15:0]       dropCount_q, dropCount_d;

   // Asserts asynchronously, releases two clocks after i_areset_n rises.
   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n) rstSync_q <= '0;
      else             rstSync_q <= {rstSync_q[0], 1'b1};
   end
   assign rstN = rstSync_q[1];

   assign frameStart = i_ce && ((state_q == S_WAIT && i_sync) || (state_q != S_WAIT && idx_q == '0));
   assign admit      = fill_q <= (LGFIFO+1)'(DEPTH - FRAME);
   assign wrWord     = {idx_q == '0, idx_q == '1, i_sample_1, i_sample_0};
   assign rdWord     = mem[rdPtr_q];
   assign pop        = (fill_q != '0) && (!tvalid_q || M_AXIS_TREADY);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      wrEn    = 1'b0;
      syncEvt = 1'b0;
      dropEvt = 1'b0;
      if (frameStart) begin
         wrEn    = admit;
         dropEvt = !admit;
         state_d = admit ? S_PASS : S_DROP;
         idx_d   = idx_q + IW'(1);
      end else if (i_ce && state_q != S_WAIT) begin
         wrEn    = (state_q == S_PASS);
         syncEvt = i_sync;
         idx_d   = idx_q + IW'(1);
      end
   end

   // An error or drop in the same cycle as i_clear takes precedence over the clear.
   always_comb begin
      syncErr_d   = syncEvt | (syncErr_q & ~i_clear);
      dropCount_d = i_clear ? 16'd0 : dropCount_q;
      if (dropEvt) begin
         if (i_clear)                     dropCount_d = 16'd1;
         else if (dropCount_q != 16'hFFFF) dropCount_d = dropCount_q + 16'd1;
      end
      fill_d = fill_q + (LGFIFO+1)'(wrEn) - (LGFIFO+1)'(pop);
   end

   always_ff @(posedge i_clk or negedge rstN) begin
      if (!rstN) begin
         state_q     <= S_WAIT;
         idx_q       <= '0;
         fill_q      <= '0;
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         syncErr_q   <= 1'b0;
         dropCount_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         fill_q      <= fill_d;
         syncErr_q   <= syncErr_d;
         dropCount_q <= dropCount_d;
         if (wrEn) wrPtr_q <= wrPtr_q + LGFIFO'(1);
         if (pop)  rdPtr_q <= rdPtr_q + LGFIFO'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (wrEn) mem[wrPtr_q] <= wrWord;
   end

   // Output register: refilled whenever it is empty or being consumed.
   always_ff @(posedge i_clk or negedge rstN) begin
      if (!rstN) begin
         tvalid_q <= 1'b0;
         tdata_q  <= '0;
         tlast_q  <= 1'b0;
         tuser_q  <= 1'b0;
      end else if (pop) begin
         tvalid_q <= 1'b1;
         tdata_q  <= rdWord[4*WIDTH-1:0];
         tlast_q  <= rdWord[4*WIDTH];
         tuser_q  <= rdWord[4*WIDTH+1];
      end else if (M_AXIS_TREADY) begin
         tvalid_q <= 1'b0;
      end
   end

   assign M_AXIS_TVALID = tvalid_q;
   assign M_AXIS_TDATA  = tdata_q;
   assign M_AXIS_TLAST  = tlast_q;
   assign M_AXIS_TUSER  = tuser_q;
   assign o_sync_err    = syncErr_q;
   assign o_drop_count  = dropCount_q;

   aNoOverflow: assert property (@(posedge i_clk) disable iff (!rstN)
      !(wrEn && fill_q == (LGFIFO+1)'(DEPTH)));

endmodule

// File: tb/tb_fft_axis_framer.sv
// Randomized scoreboard bench for fft_axis_framer: a frame-level model predicts the beat stream,
// a monitor pops and compares every accepted beat and checks stability across stalls.
module tb_fft_axis_framer;

   localparam int LGSIZE = 5;
   localparam int WIDTH  = 24;
   localparam int LGFIFO = 5;
   localparam int FRAME  = 16;
   localparam int SW     = 2 * WIDTH;
   localparam int BW     = 4 * WIDTH + 2;

   logic           i_clk = 1'b0;
   logic           i_areset_n = 1'b0;
   logic           i_ce = 1'b0;
   logic           i_sync = 1'b0;
   logic           i_clear = 1'b0;
   logic [SW-1:0]  i_sample_0 = '0;
   logic [SW-1:0]  i_sample_1 = '0;
   logic           M_AXIS_TREADY = 1'b0;
   logic           M_AXIS_TVALID;
   logic [4*WIDTH-1:0] M_AXIS_TDATA;
   logic           M_AXIS_TLAST;
   logic           M_AXIS_TUSER;
   logic           o_sync_err;
   logic [15:0]    o_drop_count;

   int checks = 0;
   int failures = 0;
   logic [BW-1:0] expQ[$];
   int  readyMode = 0;
   int  lastSeen = 0;
   int  dataCnt = 0;
   bit  modelSynced = 0;
   int  modelIdx = 0;
   bit  modelAdmit = 0;
   bit  expSyncErr = 0;
   int  expDrops = 0;
   logic [BW-1:0] prevWord = '0;
   bit  prevStall = 0;

   fft_axis_framer #(.LGSIZE(LGSIZE), .WIDTH(WIDTH), .LGFIFO(LGFIFO)) dut (
      .i_clk(i_clk), .i_areset_n(i_areset_n), .i_ce(i_ce),
      .i_sample_0(i_sample_0), .i_sample_1(i_sample_1), .i_sync(i_sync), .i_clear(i_clear),
      .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY), .M_AXIS_TDATA(M_AXIS_TDATA),
      .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TUSER(M_AXIS_TUSER),
      .o_sync_err(o_sync_err), .o_drop_count(o_drop_count)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) begin
      #1;
      if (readyMode == 0)      M_AXIS_TREADY = 1'b0;
      else if (readyMode == 1) M_AXIS_TREADY = 1'b1;
      else                     M_AXIS_TREADY = 1'($urandom_range(0, 1));
   end

   task automatic checkOutput(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // One input cycle; the model decides framing, admission and status from the rules directly.
   task automatic applyStimulus(input bit ce, input bit sync, input bit clr,
                                input logic [SW-1:0] s0, input logic [SW-1:0] s1);
      bit start = 0;
      bit syncEvt = 0;
      bit dropEvt = 0;
      i_ce = ce; i_sync = sync; i_clear = clr; i_sample_0 = s0; i_sample_1 = s1;
      if (ce) begin
         if (!modelSynced)       start = sync;
         else if (modelIdx == 0) start = 1;
         else if (sync)          syncEvt = 1;
         if (start) begin
            modelAdmit  = (expQ.size() <= FRAME);
            dropEvt     = !modelAdmit;
            modelSynced = 1;
         end
         if (modelSynced) begin
            if (modelAdmit) expQ.push_back({modelIdx == 0, modelIdx == FRAME - 1, s1, s0});
            modelIdx = (modelIdx + 1) % FRAME;
         end
      end
      expSyncErr = syncEvt | (expSyncErr & !clr);
      if (dropEvt)  expDrops = clr ? 1 : (expDrops < 65535 ? expDrops + 1 : expDrops);
      else if (clr) expDrops = 0;
      @(negedge i_clk);
      i_ce = 1'b0; i_sync = 1'b0; i_clear = 1'b0;
   endtask

   task automatic sendFrame(input int extraSyncAt, input int clearAt, input bit incData, input int gap);
      logic [SW-1:0] s0, s1;
      for (int i = 0; i < FRAME; i++) begin
         if (incData) begin
            s0 = SW'(2 * dataCnt);
            s1 = SW'(2 * dataCnt + 1);
            dataCnt++;
         end else begin
            s0 = SW'({$urandom(), $urandom()});
            s1 = SW'({$urandom(), $urandom()});
         end
         applyStimulus(1'b1, i == 0 || i == extraSyncAt, i == clearAt, s0, s1);
         repeat (gap) @(negedge i_clk);
      end
   endtask

   task automatic checkStatus(input string name);
      logic [15:0] d;
      d = expDrops[15:0];
      checkOutput({name, "_sync_err"}, o_sync_err, expSyncErr);
      checkOutput({name, "_drops"}, o_drop_count, d);
   endtask

   task automatic waitDrain(input string name);
      int n = 0;
      while ((expQ.size() != 0 || M_AXIS_TVALID) && n < 2000) begin
         @(negedge i_clk);
         n++;
      end
      checkOutput({name, "_drained"}, BW'(expQ.size()), '0);
      checkOutput({name, "_tvalid_idle"}, M_AXIS_TVALID, 1'b0);
   endtask

   // Monitor: sampled on the falling edge, a beat is consumed when TVALID and TREADY are both high.
   always @(negedge i_clk) begin
      logic [BW-1:0] cur;
      cur = {M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TDATA};
      if (!i_areset_n) begin
         prevStall = 0;
      end else begin
         if (prevStall) begin
            checkOutput("stall_valid", M_AXIS_TVALID, 1'b1);
            checkOutput("stall_hold", cur, prevWord);
         end
         if (M_AXIS_TVALID && M_AXIS_TREADY) begin
            if (expQ.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_beat actual=%h expected=none", cur);
            end else begin
               checkOutput("beat", cur, expQ.pop_front());
            end
            if (M_AXIS_TLAST) lastSeen++;
         end
         prevStall = M_AXIS_TVALID && !M_AXIS_TREADY;
         prevWord  = cur;
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int l0;
      readyMode = 1;
      repeat (3) @(negedge i_clk);
      i_areset_n = 1'b1;
      repeat (5) @(negedge i_clk);
      checkOutput("reset_tvalid", M_AXIS_TVALID, 1'b0);
      checkOutput("reset_tlast", M_AXIS_TLAST, 1'b0);
      checkOutput("reset_tuser", M_AXIS_TUSER, 1'b0);
      checkOutput("reset_tdata", M_AXIS_TDATA, '0);
      checkStatus("reset");

      $display("[TB] test 1: pre-sync beats ignored, latency");
      l0 = lastSeen;
      repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, SW'($urandom()), SW'($urandom()));
      for (int i = 0; i < FRAME; i++) begin
         applyStimulus(1'b1, i == 0, 1'b0, SW'(i + 1000), SW'(i + 2000));
         if (i == 0) checkOutput("latency_1cyc", M_AXIS_TVALID, 1'b0);
         if (i == 1) checkOutput("latency_2cyc", M_AXIS_TVALID, 1'b1);
      end
      waitDrain("t1");
      checkOutput("t1_tlasts", BW'(lastSeen - l0), BW'(1));

      $display("[TB] test 2: backpressure admits two frames, drops third");
      readyMode = 0;
      @(negedge i_clk);
      l0 = lastSeen;
      repeat (3) sendFrame(-1, -1, 1'b1, 0);
      checkOutput("t2_drop_one", o_drop_count, 16'd1);
      checkStatus("t2");
      readyMode = 1;
      waitDrain("t2");
      checkOutput("t2_tlasts", BW'(lastSeen - l0), BW'(2));
      applyStimulus(1'b0, 1'b0, 1'b1, '0, '0);
      checkStatus("t2_clear");

      $display("[TB] test 3: random backpressure, 10 frames");
      readyMode = 2;
      l0 = lastSeen;
      for (int f = 0; f < 10; f++) begin
         int n = 0;
         while (expQ.size() > FRAME - 4 && n < 1000) begin
            @(negedge i_clk);
            n++;
         end
         sendFrame(-1, -1, 1'b1, 0);
      end
      readyMode = 1;
      waitDrain("t3");
      checkOutput("t3_no_drops", o_drop_count, 16'd0);
      checkOutput("t3_tlasts", BW'(lastSeen - l0), BW'(10));
      checkStatus("t3");

      $display("[TB] test 4: unexpected sync and clear");
      sendFrame(5, -1, 1'b0, 0);
      checkOutput("t4_sync_err_set", o_sync_err, 1'b1);
      checkStatus("t4");
      applyStimulus(1'b0, 1'b0, 1'b1, '0, '0);
      checkOutput("t4_cleared", o_sync_err, 1'b0);
      sendFrame(3, 3, 1'b0, 0);
      checkOutput("t4_err_wins", o_sync_err, 1'b1);
      checkStatus("t4b");
      applyStimulus(1'b0, 1'b0, 1'b1, '0, '0);
      waitDrain("t4");

      $display("[TB] test 5: reset mid-frame");
      for (int i = 0; i < 8; i++)
         applyStimulus(1'b1, i == 0, 1'b0, SW'($urandom()), SW'($urandom()));
      checkOutput("t5_tvalid_before", M_AXIS_TVALID, 1'b1);
      #2 i_areset_n = 1'b0;
      #1 checkOutput("t5_async_drop", M_AXIS_TVALID, 1'b0);
      expQ.delete();
      modelSynced = 0; modelIdx = 0; modelAdmit = 0; expSyncErr = 0; expDrops = 0;
      @(negedge i_clk);
      #2 i_areset_n = 1'b1;
      repeat (4) @(negedge i_clk);
      checkStatus("t5_reset");
      repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, SW'($urandom()), SW'($urandom()));
      repeat (3) @(negedge i_clk);
      checkOutput("t5_ignored", M_AXIS_TVALID, 1'b0);
      sendFrame(-1, -1, 1'b0, 0);
      waitDrain("t5");

      $display("[TB] test 6: sparse i_ce");
      l0 = lastSeen;
      repeat (3) sendFrame(-1, -1, 1'b1, 2);
      waitDrain("t6");
      checkOutput("t6_tlasts", BW'(lastSeen - l0), BW'(3));
      checkStatus("t6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
